// File: rtl/mt_thread_scheduler.sv
// Barrel-style thread scheduler: round-robin issue among active threads, with
// at most one instruction per thread in the issue-to-writeback pipe.

module mt_ts_thread_lane #(
  parameter int   TID        = 0,
  parameter int   PIPE_DEPTH = 4,
  parameter int   BITS       = 3,
  parameter logic RST_ACTIVE = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  input  logic                           i_stop,
  input  logic [PIPE_DEPTH-1:0]          i_stg_vld,
  input  logic [PIPE_DEPTH-1:0][BITS-1:0] i_stg_tid,
  output logic                           o_active,
  output logic                           o_eligible
);
  logic r_active;
  logic w_in_flight;

  // Stop wins over start; redundant requests leave the bit unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_active <= RST_ACTIVE;
    else if (i_stop)  r_active <= 1'b0;
    else if (i_start) r_active <= 1'b1;
  end

  always_comb begin
    w_in_flight = 1'b0;
    for (int s = 0; s < PIPE_DEPTH; s++)
      if (i_stg_vld[s] && (i_stg_tid[s] == BITS'(TID))) w_in_flight = 1'b1;
  end

  assign o_active   = r_active;
  assign o_eligible = r_active & ~w_in_flight;
endmodule

module mt_thread_scheduler #(
  parameter int NUM_THREADS = 8,
  parameter int PIPE_DEPTH  = 4,
  parameter logic [NUM_THREADS-1:0] RESET_MASK = 'h01
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               thread_start,
  input  logic [$clog2(NUM_THREADS)-1:0]     start_tid,
  input  logic                               thread_stop,
  input  logic [$clog2(NUM_THREADS)-1:0]     stop_tid,
  input  logic                               wb_we_in,
  output logic                               issue_valid,
  output logic [$clog2(NUM_THREADS)-1:0]     issue_tid,
  output logic                               wb_valid,
  output logic [$clog2(NUM_THREADS)-1:0]     wb_tid,
  output logic                               rf_we,
  output logic [NUM_THREADS-1:0]             active_mask,
  output logic                               idle
);
  localparam int BITS_THREADS = $clog2(NUM_THREADS);

  logic [PIPE_DEPTH-1:0]                   r_vld;
  logic [PIPE_DEPTH-1:0][BITS_THREADS-1:0] r_tid;
  logic [BITS_THREADS-1:0]                 r_last_tid;
  logic [NUM_THREADS-1:0]                  w_elig;
  logic [NUM_THREADS-1:0]                  w_active;
  logic [BITS_THREADS-1:0]                 w_idx;
  logic [BITS_THREADS-1:0]                 w_sel;
  logic                                    w_found;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
    mt_ts_thread_lane #(
      .TID        (t),
      .PIPE_DEPTH (PIPE_DEPTH),
      .BITS       (BITS_THREADS),
      .RST_ACTIVE (RESET_MASK[t])
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_start    (thread_start && (start_tid == BITS_THREADS'(t))),
      .i_stop     (thread_stop  && (stop_tid  == BITS_THREADS'(t))),
      .i_stg_vld  (r_vld),
      .i_stg_tid  (r_tid),
      .o_active   (w_active[t]),
      .o_eligible (w_elig[t])
    );
  end

  // Round-robin search starting just after the last issued thread; the
  // k == NUM_THREADS step wraps back onto last_tid itself.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      w_idx = r_last_tid + BITS_THREADS'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign issue_valid = w_found;
  assign issue_tid   = w_found ? w_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_last_tid <= BITS_THREADS'(NUM_THREADS - 1);
    else if (issue_valid) r_last_tid <= issue_tid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_tid <= '0;
    end else begin
      r_vld[0] <= issue_valid;
      r_tid[0] <= issue_tid;
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_tid[s] <= r_tid[s-1];
      end
    end
  end

  assign wb_valid    = r_vld[PIPE_DEPTH-1];
  assign wb_tid      = r_tid[PIPE_DEPTH-1];
  assign rf_we       = wb_valid & wb_we_in;
  assign active_mask = w_active;
  assign idle        = ~|w_active & ~|r_vld;
endmodule

// File: tb/tb_mt_thread_scheduler.sv
// Randomized scoreboard bench for mt_thread_scheduler against a
// per-thread issue-time reference model.

module tb_mt_thread_scheduler;
  localparam int NT = 8;
  localparam int PD = 4;
  localparam logic [NT-1:0] RMASK = 8'h01;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       thread_start = 1'b0, thread_stop = 1'b0, wb_we_in = 1'b0;
  logic [2:0] start_tid = '0, stop_tid = '0;
  logic       issue_valid, wb_valid, rf_we, idle;
  logic [2:0] issue_tid, wb_tid;
  logic [NT-1:0] active_mask;

  mt_thread_scheduler #(.NUM_THREADS(NT), .PIPE_DEPTH(PD), .RESET_MASK(RMASK)) dut (
    .clk(clk), .rst(rst),
    .thread_start(thread_start), .start_tid(start_tid),
    .thread_stop(thread_stop), .stop_tid(stop_tid),
    .wb_we_in(wb_we_in),
    .issue_valid(issue_valid), .issue_tid(issue_tid),
    .wb_valid(wb_valid), .wb_tid(wb_tid), .rf_we(rf_we),
    .active_mask(active_mask), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct { int c; int t; } ev_t;
  ev_t issq[$];
  ev_t wbq[$];

  int total = 0, bad = 0;
  int cyc = 0;
  bit mon_en = 0;

  // Reference model state
  bit [NT-1:0] m_act = RMASK;
  int m_last = NT - 1;
  int hist[NT];
  bit m_we, m_idle, m_iss_v;
  int m_iss_t;
  bit [NT-1:0] m_mask;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit st, input int stt, input bit sp, input int spt,
                      input bit we, input bit r);
    bit infl [NT];
    bit any_infl;
    @(posedge clk); #1;
    rst = r; thread_start = st; start_tid = 3'(stt);
    thread_stop = sp; stop_tid = 3'(spt); wb_we_in = we;
    cyc++;
    mon_en = 1'b1;
    if (r) begin
      m_act = RMASK; m_last = NT - 1;
      foreach (hist[t]) hist[t] = -1000;
      wbq.delete();
    end
    any_infl = 1'b0;
    for (int t = 0; t < NT; t++) begin
      infl[t] = (cyc - hist[t] >= 1) && (cyc - hist[t] <= PD);
      if (infl[t]) any_infl = 1'b1;
    end
    m_iss_v = 1'b0; m_iss_t = 0;
    for (int k = 1; k <= NT; k++) begin
      int t;
      t = (m_last + k) % NT;
      if (!m_iss_v && m_act[t] && !infl[t]) begin m_iss_v = 1'b1; m_iss_t = t; end
    end
    m_we = we; m_mask = m_act;
    m_idle = (m_act == 0) && !any_infl;
    if (m_iss_v) issq.push_back('{cyc, m_iss_t});
    if (!r) begin
      if (m_iss_v) begin
        wbq.push_back('{cyc + PD, m_iss_t});
        hist[m_iss_t] = cyc;
        m_last = m_iss_t;
      end
      if (st) m_act[stt] = 1'b1;
      if (sp) m_act[spt] = 1'b0;
    end
  endtask

  bit e_iss, e_wb;
  always @(negedge clk) begin
    if (mon_en) begin
      e_iss = (issq.size() > 0) && (issq[0].c == cyc);
      chk("issue_valid", issue_valid, e_iss);
      if (e_iss) begin
        chk("issue_tid", issue_tid, issq[0].t);
        void'(issq.pop_front());
      end else chk("issue_tid_zero", issue_tid, 0);
      e_wb = (wbq.size() > 0) && (wbq[0].c == cyc);
      chk("wb_valid", wb_valid, e_wb);
      if (e_wb) begin
        chk("wb_tid", wb_tid, wbq[0].t);
        void'(wbq.pop_front());
      end
      chk("rf_we", rf_we, e_wb && m_we);
      chk("active_mask", active_mask, m_mask);
      chk("idle", idle, m_idle);
    end
  end

  initial begin
    bit found;
    int stale;
    foreach (hist[t]) hist[t] = -1000;
    // reset and lone-thread cadence
    repeat (3) step(0, 0, 0, 0, 1, 1);
    repeat (12) step(0, 0, 0, 0, 1, 0);
    // bring up threads 1..7, then steady rotation
    for (int t = 1; t < NT; t++) step(1, t, 0, 0, 1, 0);
    repeat (20) step(0, 0, 0, 0, 1, 0);
    // stop tid2 the cycle after it issues
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 0, 1, 0);
      if (m_iss_v && m_iss_t == 2) found = 1'b1;
    end
    chk("tid2_seen", found, 1);
    step(0, 0, 1, 2, 1, 0);
    repeat (16) step(0, 0, 0, 0, 1, 0);
    // same-tid start/stop, and split start/stop
    step(1, 5, 1, 5, 0, 0);
    step(1, 3, 1, 4, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    step(1, 5, 1, 5, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1, 0);
    // all active, then reset with pipe full
    for (int t = 0; t < NT; t++) step(1, t, 0, 0, 1, 0);
    repeat (10) step(0, 0, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 1, 1);
    repeat (10) step(0, 0, 0, 0, 1, 0);
    // drain everything to idle
    for (int t = 0; t < NT; t++) step(0, 0, 1, t, 1, 0);
    repeat (8) step(0, 0, 0, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, NT - 1),
           $urandom_range(0, 9) < 2, $urandom_range(0, NT - 1),
           $urandom_range(0, 1), $urandom_range(0, 99) == 0);
    end
    repeat (8) step(0, 0, 0, 0, 1, 0);
    @(negedge clk); #1;
    stale = 0;
    foreach (issq[i]) if (issq[i].c <= cyc) stale++;
    foreach (wbq[i]) if (wbq[i].c <= cyc) stale++;
    chk("queue_stale", stale, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mt_thread_scheduler.md
MT_THREAD_SCHEDULER -- requirements
Module: mt_thread_scheduler

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 8: number of hardware threads (power of two, >=2).
REQ-002 SHALL have parameter PIPE_DEPTH, default 4: issue-to-writeback distance in cycles (>=1).
REQ-003 SHALL have parameter RESET_MASK, default 8'h01: active-thread mask loaded at reset (NUM_THREADS bits).
REQ-004 SHALL derive localparam BITS_THREADS = $clog2(NUM_THREADS).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port thread_start  input  1  request to set start_tid active.
REQ-008 SHALL have port start_tid  input  BITS_THREADS  thread to activate.
REQ-009 SHALL have port thread_stop  input  1  request to clear stop_tid active.
REQ-010 SHALL have port stop_tid  input  BITS_THREADS  thread to deactivate.
REQ-011 SHALL have port wb_we_in  input  1  writeback-stage instruction writes a register.
REQ-012 SHALL have port issue_valid  output  1  an instruction is issued this cycle.
REQ-013 SHALL have port issue_tid  output  BITS_THREADS  thread issued this cycle; drives register-file tid_read.
REQ-014 SHALL have port wb_valid  output  1  writeback stage holds a valid instruction.
REQ-015 SHALL have port wb_tid  output  BITS_THREADS  writeback thread; drives register-file tid_write.
REQ-016 SHALL have port rf_we  output  1  register-file write_enable.
REQ-017 SHALL have port active_mask  output  NUM_THREADS  registered active bit per thread.
REQ-018 SHALL have port idle  output  1  no active thread and no instruction in flight.

Function
REQ-019 SHALL hold a PIPE_DEPTH-entry shift register of {valid, tid}; stage 1 loads {issue_valid, issue_tid} each cycle; stage PIPE_DEPTH drives wb_valid/wb_tid.
REQ-020 SHALL define in_flight[t] = 1 when any shift-register stage is valid with tid t.
REQ-021 SHALL define eligible[t] = active_mask[t] AND NOT in_flight[t].
REQ-022 SHALL select issue_tid combinationally as the first eligible thread searching upward from last_tid+1 modulo NUM_THREADS; issue_valid = OR of eligible.
REQ-023 SHALL update registered last_tid to issue_tid only in cycles where issue_valid=1; bubble cycles leave it unchanged.
REQ-024 SHALL drive issue_tid = 0 when issue_valid = 0.
REQ-025 SHALL guarantee one thread never has two instructions in flight; a lone active thread issues once every PIPE_DEPTH+1 cycles.
REQ-026 SHALL, with NUM_THREADS > PIPE_DEPTH and all threads active, issue every cycle in strict order 0,1,...,NUM_THREADS-1,0.
REQ-027 SHALL update active_mask one cycle after thread_start/thread_stop; a same-cycle request does not affect that cycle's issue.
REQ-028 SHALL give stop priority when thread_start and thread_stop name the same tid in one cycle; start and stop on different tids both apply.
REQ-029 SHALL ignore start of an already active thread and stop of an inactive thread.
REQ-030 SHALL let instructions already in flight for a stopped thread complete normally through writeback.
REQ-031 SHALL drive rf_we = wb_valid AND wb_we_in, combinationally.
REQ-032 SHALL drive idle = (active_mask == 0) AND no stage valid, combinationally.

Reset
REQ-033 SHALL, while rst=1, clear all shift-register stages, set last_tid = NUM_THREADS-1, load active_mask = RESET_MASK.
REQ-034 SHALL, during reset, present wb_valid=0, rf_we=0; issue outputs follow REQ-022 from reset state.
REQ-035 SHALL discard in-flight instructions when reset asserts mid-operation; none reach writeback.

Verification
REQ-036 SHALL cover: reset release, RESET_MASK=8'h01 -> tid0 issued cycle 0, bubbles cycles 1-4, tid0 again cycle 5; wb_valid=1, wb_tid=0 at cycle 4.
REQ-037 SHALL cover: start tids 1..7 one per cycle, then steady state -> issue_tid 0,1,...,7,0 with no bubbles, wb_tid equals issue_tid delayed 4 cycles.
REQ-038 SHALL cover: wb_we_in held 1 constantly -> rf_we=1 exactly in cycles where wb_valid=1.
REQ-039 SHALL cover: stop tid2 one cycle after tid2 issued -> tid2 never reissued, its writeback still appears 4 cycles after issue, rotation skips 2.
REQ-040 SHALL cover: same-cycle start and stop of tid5 (inactive) -> active_mask[5] stays 0; start tid3 with stop tid4 -> bit3 set, bit4 cleared.
REQ-041 SHALL cover: rst asserted with 4 instructions in flight -> wb_valid=0, idle=0 with RESET_MASK nonzero, issue resumes at tid0 after release.
